lsu_mem_stage: RTL and testbench
================================

// Module: lsu_mem_stage
// PURPOSE
//  Load/store unit between execute and the register file write port. Takes one memory op per issue.
//  Drives a req/gnt/rvalid data-memory port and aligns load data with sign/zero extension.
//  Produces the loaded-data write (load data, DR_EN, RWR_EN, RD) consumed by the register file.
//  Stalls upstream via busy_o.
// PARAMETERS
//  AW  32  byte-address width
//  DW  32  data width; fixed at 32, other values unsupported
// PORTS
//  clk_i         in   1   clock; all state on posedge
//  rstn_i        in   1   reset, asynchronous, active-low
//  req_i         in   1   execute issues a memory op this cycle
//  we_i          in   1   1=store, 0=load
//  funct3_i      in   3   RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  addr_i        in   AW  byte address (rs1+imm)
//  wdata_i       in   32  store data (rs2)
//  rd_i          in   5   load destination register
//  busy_o        out  1   op in flight; upstream holds and must not issue
//  mem_req_o     out  1   memory request, held until mem_gnt_i
//  mem_we_o      out  1   memory write enable
//  mem_be_o      out  4   byte enables
//  mem_addr_o    out  AW  word-aligned address ({addr[AW-1:2],2'b00})
//  mem_wdata_o   out  32  lane-replicated store data
//  mem_gnt_i     in   1   memory accepted request
//  mem_rvalid_i  in   1   read data valid
//  mem_rdata_i   in   32  read word
//  ld_data_o     out  32  aligned, extended load data (to reg-file load-data input)
//  dr_en_o       out  1   select load data for write-back
//  rwr_en_o      out  1   register write enable
//  rd_o          out  5   register write address
//  misalign_o    out  1   misaligned-access flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset:
//   - All outputs 0; FSM state IDLE.
//   - Reset mid-op aborts. A later mem_rvalid_i is ignored in IDLE.
//  FSM states: IDLE, REQ, WAIT, WB.
//   - IDLE: req_i=1 registers we/funct3/addr/wdata/rd and goes to REQ. busy_o=0 only here.
//   - REQ: mem_req_o=1 with stable addr/be/we/wdata.
//     - gnt & store: go to IDLE.
//     - gnt & load: go to WAIT.
//     - no gnt: stay in REQ.
//   - WAIT: mem_rvalid_i=1 registers the extended data into ld_data_o and goes to WB. rvalid in REQ is ignored.
//   - WB: one-cycle pulse of dr_en_o=1 and rwr_en_o=(rd!=0); rd_o valid. Then IDLE.
//  Latency:
//   - Load with gnt in the first REQ cycle and rvalid one cycle later: req_i at edge N gives WB at cycle N+3.
//   - Store: mem_req_o high at N+1; IDLE at N+2.
//  req_i while busy_o=1 is ignored; no queueing.
//  Byte enables (o = addr[1:0]):
//   - B/BU: 4'b0001<<o
//   - H/HU: 4'b0011<<{o[1],1'b0}
//   - W: 4'b1111
//  Store data replication:
//   - SB: {4{wdata[7:0]}}
//   - SH: {2{wdata[15:0]}}
//   - SW: as-is
//  Load extraction:
//   - Select the byte/half lane by o.
//   - Sign-extend for B/H; zero-extend for BU/HU.
//  Reserved funct3:
//   - Loads: 011/110/111 are treated as W.
//   - Stores: any funct3 other than 000/001 is treated as W.
//  rd=0 load: the bus access is still performed; rwr_en_o stays 0.
// CONFIGURATION
//  Macro LSU_MISALIGN_TRAP_EN.
//  Defined:
//   - H with addr[0]=1, or W with addr[1:0]!=0, skips REQ.
//   - misalign_o pulses 1 cycle (next cycle), no bus access, no write-back, FSM goes to IDLE.
//  Undefined:
//   - misalign_o tied 0.
//   - H is forced to lane {addr[1],0} and W to lane 0; the access proceeds normally.
// STRUCTURE
//  Package lsu_pkg:
//   - typedef enum logic[1:0] lsu_state_e {IDLE,REQ,WAIT,WB}
//   - localparams F3_B/F3_H/F3_W/F3_BU/F3_HU
//   - function be_gen()
//  Sub-module lsu_load_align: combinational lane select + extension (rdata, offset, funct3 -> 32b).
// TESTING
//  1. LB, addr 0x103, rdata 0x80AA_BB_CC, gnt immediate, rvalid +1 -> ld_data_o=0xFFFFFF80, dr_en/rwr_en pulse 1 cycle at N+3, rd_o=rd_i.
//  2. LHU, addr 0x102, rdata 0x8001_1234 -> ld_data_o=0x00008001. Same with LH -> 0xFFFF8001.
//  3. SB, addr 0x201, wdata 0x55 -> mem_be_o=0010, mem_wdata_o=0x55555555, mem_addr_o=0x200. No rwr_en_o pulse.
//  4. gnt withheld 5 cycles -> mem_req_o and all address/data outputs stable, busy_o=1; second req_i during this is ignored.
//  5. rstn_i low during WAIT, then rvalid -> outputs 0, no write-back, next op runs normally.
//  6. LW addr 0x2 -> with LSU_MISALIGN_TRAP_EN: misalign_o=1, mem_req_o never 1. Without: access to 0x0 with be=1111.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Misaligned trapping is built with LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    WB
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } lsu_size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Reserved encodings fall back to a word access.
  function automatic lsu_size_e size_of(
    input logic       we,
    input logic [2:0] f3
  );
    lsu_size_e s;
    s = SZ_W;
    unique case (1'b1)
      f3 == F3_B:          s = SZ_B;
      f3 == F3_H:          s = SZ_H;
      !we && f3 == F3_BU:  s = SZ_B;
      !we && f3 == F3_HU:  s = SZ_H;
      default:             s = SZ_W;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] be_gen(
    input lsu_size_e  sz,
    input logic [1:0] off
  );
    logic [3:0] be;
    be = 4'b1111;
    unique case (sz)
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = 4'b0011 << {off[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_mem_stage_load_align.sv
// Load lane select and sign/zero extension.
// Halfwords use lane {off[1],0}; words use the full read word.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  lsu_size_e   sz;
  logic [7:0]  b;
  logic [15:0] h;
  logic        sext;

  assign sz   = size_of(1'b0, funct3_i);
  assign b    = rdata_i[{off_i, 3'b000} +: 8];
  assign h    = off_i[1] ? rdata_i[31:16]
                         : rdata_i[15:0];
  assign sext = ~funct3_i[2];

  always_comb begin
    data_o = rdata_i;
    unique case (sz)
      SZ_B:    data_o = {{24{sext & b[7]}}, b};
      SZ_H:    data_o = {{16{sext & h[15]}}, h};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store unit: req/gnt/rvalid port, load align, write-back.
// LSU_MISALIGN_TRAP_EN: trap misaligned H/W instead of forcing lanes.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          req_i,
  input  logic          we_i,
  input  logic [2:0]    funct3_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [4:0]    rd_i,
  output logic          busy_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [3:0]    mem_be_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic [DW-1:0] ld_data_o,
  output logic          dr_en_o,
  output logic          rwr_en_o,
  output logic [4:0]    rd_o,
  output logic          misalign_o
);

  lsu_state_e    state_q, state_d;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [4:0]    rd_q;
  logic [DW-1:0] ld_q;
  logic [DW-1:0] algn;
  logic [DW-1:0] rep;
  lsu_size_e     sz_q;
  logic          take;
  logic          trap;
  logic          in_req;
  logic          in_wb;

  assign take = (state_q == IDLE) && req_i;

`ifdef LSU_MISALIGN_TRAP_EN
  lsu_size_e sz_in;
  logic      mis_q;

  assign sz_in = size_of(we_i, funct3_i);
  assign trap  = (sz_in == SZ_H && addr_i[0])
              || (sz_in == SZ_W && addr_i[1:0] != 2'b00);
  assign misalign_o = mis_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) mis_q <= 1'b0;
    else         mis_q <= take && trap;
  end
`else
  assign trap       = 1'b0;
  assign misalign_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (take && !trap) state_d = REQ;
      REQ:  if (mem_gnt_i) state_d = we_q ? IDLE : WAIT;
      WAIT: if (mem_rvalid_i) state_d = WB;
      WB:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 5'd0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        we_q    <= we_i;
        f3_q    <= funct3_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        rd_q    <= rd_i;
      end
      if (state_q == WAIT && mem_rvalid_i)
        ld_q <= algn;
    end
  end

  lsu_load_align u_align (
    .rdata_i  (mem_rdata_i),
    .off_i    (addr_q[1:0]),
    .funct3_i (f3_q),
    .data_o   (algn)
  );

  assign sz_q = size_of(we_q, f3_q);

  always_comb begin
    rep = wdata_q;
    unique case (sz_q)
      SZ_B:    rep = {4{wdata_q[7:0]}};
      SZ_H:    rep = {2{wdata_q[15:0]}};
      default: rep = wdata_q;
    endcase
  end

  assign in_req = state_q == REQ;
  assign in_wb  = state_q == WB;

  assign busy_o      = state_q != IDLE;
  assign mem_req_o   = in_req;
  assign mem_we_o    = in_req & we_q;
  assign mem_be_o    = in_req ? be_gen(sz_q, addr_q[1:0])
                              : 4'b0000;
  assign mem_addr_o  = in_req ? {addr_q[AW-1:2], 2'b00}
                              : '0;
  assign mem_wdata_o = in_req ? rep : '0;

  assign ld_data_o = ld_q;
  assign dr_en_o   = in_wb;
  assign rwr_en_o  = in_wb && rd_q != 5'd0;
  assign rd_o      = in_wb ? rd_q : 5'd0;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: transaction model plus random ops.
// Honours LSU_MISALIGN_TRAP_EN the same way as the design.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        req_i, we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic [4:0]  rd_i;
  logic        busy_o, mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] ld_data_o;
  logic        dr_en_o, rwr_en_o;
  logic [4:0]  rd_o;
  logic        misalign_o;

  always #5 clk = ~clk;

  lsu_mem_stage #(.AW(32), .DW(32)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn_i),
    .req_i        (req_i),
    .we_i         (we_i),
    .funct3_i     (funct3_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .rd_i         (rd_i),
    .busy_o       (busy_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .ld_data_o    (ld_data_o),
    .dr_en_o      (dr_en_o),
    .rwr_en_o     (rwr_en_o),
    .rd_o         (rd_o),
    .misalign_o   (misalign_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic        chk_on = 1'b0;
  logic        exp_busy, exp_req, exp_we;
  logic [3:0]  exp_be;
  logic [31:0] exp_addr, exp_wd, exp_ld;
  logic        exp_dr, exp_rwr, exp_mis;
  logic [4:0]  exp_rd;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: access size in bytes from the RV32I encoding.
  function automatic int sz(bit we, logic [2:0] f3);
    if (we) begin
      if (f3 == 3'b000) return 1;
      if (f3 == 3'b001) return 2;
      return 4;
    end
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic bit trap(bit we, logic [2:0] f3, logic [31:0] a);
    int n;
    n = sz(we, f3);
`ifdef LSU_MISALIGN_TRAP_EN
    return (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
`else
    return (n < 0) && a[0];
`endif
  endfunction

  function automatic logic [3:0] m_be(int n, logic [1:0] off);
    if (n == 1) return 4'(1 << off);
    if (n == 2) return (off >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wd(int n, logic [31:0] wd);
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < 4; i++)
      o[8*i +: 8] = wd[8*(i % n) +: 8];
    return o;
  endfunction

  function automatic logic [31:0] m_ld(logic [2:0] f3,
                                       logic [1:0] off,
                                       logic [31:0] r);
    int n, base;
    bit s;
    logic [31:0] v;
    n = sz(1'b0, f3);
    s = (f3 == 3'b000 || f3 == 3'b001);
    if (n == 4) return r;
    base = (n == 1) ? int'(off) : ((off >= 2) ? 2 : 0);
    v = r >> (8 * base);
    if (n == 1) begin
      v = v & 32'hFF;
      if (s && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else begin
      v = v & 32'hFFFF;
      if (s && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", {31'b0, busy_o}, {31'b0, exp_busy});
      chk("mem_req", {31'b0, mem_req_o}, {31'b0, exp_req});
      chk("dr_en", {31'b0, dr_en_o}, {31'b0, exp_dr});
      chk("rwr_en", {31'b0, rwr_en_o}, {31'b0, exp_rwr});
      chk("misalign", {31'b0, misalign_o}, {31'b0, exp_mis});
      if (exp_req) begin
        chk("mem_we", {31'b0, mem_we_o}, {31'b0, exp_we});
        chk("mem_be", {28'b0, mem_be_o}, {28'b0, exp_be});
        chk("mem_addr", mem_addr_o, exp_addr);
        if (exp_we) chk("mem_wdata", mem_wdata_o, exp_wd);
      end
      if (exp_dr) begin
        chk("rd", {27'b0, rd_o}, {27'b0, exp_rd});
        chk("ld_data", ld_data_o, exp_ld);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    exp_busy = 1'b0; exp_req = 1'b0; exp_we = 1'b0;
    exp_be = 4'b0; exp_addr = '0; exp_wd = '0;
    exp_dr = 1'b0; exp_rwr = 1'b0; exp_rd = '0; exp_mis = 1'b0;
  endtask

  // Noise on inputs the DUT must ignore while busy.
  task automatic junk();
    req_i       = 1'($urandom_range(0, 1));
    we_i        = 1'($urandom_range(0, 1));
    funct3_i    = 3'($urandom_range(0, 7));
    addr_i      = $urandom;
    wdata_i     = $urandom;
    rd_i        = 5'($urandom_range(0, 31));
    mem_rvalid_i = 1'($urandom_range(0, 3) == 0);
    mem_rdata_i = $urandom;
  endtask

  task automatic zero_chk(string tag);
    chk({tag, "_busy"}, {31'b0, busy_o}, 32'd0);
    chk({tag, "_req"}, {31'b0, mem_req_o}, 32'd0);
    chk({tag, "_we"}, {31'b0, mem_we_o}, 32'd0);
    chk({tag, "_be"}, {28'b0, mem_be_o}, 32'd0);
    chk({tag, "_addr"}, mem_addr_o, 32'd0);
    chk({tag, "_wdata"}, mem_wdata_o, 32'd0);
    chk({tag, "_ld"}, ld_data_o, 32'd0);
    chk({tag, "_dr"}, {31'b0, dr_en_o}, 32'd0);
    chk({tag, "_rwr"}, {31'b0, rwr_en_o}, 32'd0);
    chk({tag, "_rd"}, {27'b0, rd_o}, 32'd0);
    chk({tag, "_mis"}, {31'b0, misalign_o}, 32'd0);
  endtask

  task automatic do_op(bit we, logic [2:0] f3, logic [31:0] a,
                       logic [31:0] wd, logic [4:0] rd,
                       logic [31:0] rdat, int gd, int rvd,
                       bit lit_en, logic [31:0] lit,
                       logic [3:0] lit_be);
    int n;
    n = sz(we, f3);
    req_i = 1'b1; we_i = we; funct3_i = f3;
    addr_i = a; wdata_i = wd; rd_i = rd;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    set_idle();
    step();
    req_i = 1'b0;
    if (trap(we, f3, a)) begin
      exp_mis = 1'b1;
      if (lit_en) chk("lit_mis", {31'b0, misalign_o}, 32'd1);
      step();
      exp_mis = 1'b0;
      return;
    end
    for (int k = 0; k <= gd; k++) begin
      exp_busy = 1'b1; exp_req = 1'b1; exp_we = we;
      exp_be   = m_be(n, a[1:0]);
      exp_addr = {a[31:2], 2'b00};
      exp_wd   = m_wd(n, wd);
      junk();
      mem_gnt_i = (k == gd);
      if (lit_en && k == 0) begin
        chk("lit_be", {28'b0, mem_be_o}, {28'b0, lit_be});
        if (we) chk("lit_wdata", mem_wdata_o, lit);
      end
      step();
    end
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; req_i = 1'b0;
    exp_req = 1'b0;
    if (we) begin
      set_idle();
      return;
    end
    for (int k = 0; k <= rvd; k++) begin
      exp_busy = 1'b1;
      junk();
      mem_rvalid_i = (k == rvd);
      if (k == rvd) mem_rdata_i = rdat;
      step();
    end
    mem_rvalid_i = 1'b0; req_i = 1'b0;
    exp_busy = 1'b1; exp_dr = 1'b1; exp_rwr = (rd != 5'd0);
    exp_rd = rd; exp_ld = m_ld(f3, a[1:0], rdat);
    if (lit_en) chk("lit_ld", ld_data_o, lit);
    step();
    set_idle();
  endtask

  initial begin
    rstn_i = 1'b0;
    req_i = 1'b0; we_i = 1'b0; funct3_i = 3'b0;
    addr_i = '0; wdata_i = '0; rd_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    exp_ld = '0;
    set_idle();
    chk_on = 1'b1;
    step();
    step();
    zero_chk("reset");
    rstn_i = 1'b1;
    step();

    // LB sign, LHU/LH, SB replication, long grant stall
    do_op(1'b0, 3'b000, 32'h103, 32'h0, 5'd7, 32'h80AA_BBCC,
          0, 0, 1'b1, 32'hFFFF_FF80, 4'b1000);
    do_op(1'b0, 3'b101, 32'h102, 32'h0, 5'd4, 32'h8001_1234,
          0, 0, 1'b1, 32'h0000_8001, 4'b1100);
    do_op(1'b0, 3'b001, 32'h102, 32'h0, 5'd4, 32'h8001_1234,
          0, 0, 1'b1, 32'hFFFF_8001, 4'b1100);
    do_op(1'b1, 3'b000, 32'h201, 32'h55, 5'd9, 32'h0,
          0, 0, 1'b1, 32'h5555_5555, 4'b0010);
    do_op(1'b0, 3'b010, 32'h300, 32'h0, 5'd9, 32'hDEAD_BEEF,
          5, 1, 1'b0, 32'h0, 4'b0);
    do_op(1'b0, 3'b010, 32'h304, 32'h0, 5'd0, 32'h1234_5678,
          0, 2, 1'b0, 32'h0, 4'b0);

    // reset during WAIT, then stray rvalid in IDLE
    req_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010;
    addr_i = 32'h40; wdata_i = '0; rd_i = 5'd3;
    set_idle();
    step();
    req_i = 1'b0;
    exp_busy = 1'b1; exp_req = 1'b1; exp_we = 1'b0;
    exp_be = 4'hF; exp_addr = 32'h40;
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0; exp_req = 1'b0;
    step();
    rstn_i = 1'b0;
    set_idle();
    #1;
    zero_chk("midrst");
    #2;
    rstn_i = 1'b1;
    step();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
    step();
    mem_rvalid_i = 1'b0;
    step();
    do_op(1'b0, 3'b100, 32'h41, 32'h0, 5'd12, 32'h00F0_8000,
          0, 0, 1'b1, 32'h0000_0080, 4'b0010);

    // LW at 0x2: trap, or forced word lane 0
`ifdef LSU_MISALIGN_TRAP_EN
    do_op(1'b0, 3'b010, 32'h2, 32'h0, 5'd5, 32'h1122_3344,
          0, 0, 1'b1, 32'h0, 4'b0);
`else
    do_op(1'b0, 3'b010, 32'h2, 32'h0, 5'd5, 32'h1122_3344,
          0, 0, 1'b1, 32'h1122_3344, 4'b1111);
`endif

    for (int i = 0; i < 300; i++) begin
      do_op(1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)),
            $urandom, $urandom,
            5'($urandom_range(0, 31)),
            $urandom,
            $urandom_range(0, 3),
            $urandom_range(0, 3),
            1'b0, 32'h0, 4'b0);
      if ($urandom_range(0, 3) == 0) begin
        req_i = 1'b0;
        step();
      end
    end

    step();
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
